// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder.
// Holds the default operand/chunk widths, the stage-count helper and the
// configuration legality check used at elaboration time.
package add_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Number of pipeline stages (one chunk added per stage).
  function automatic int chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal when the operand splits into whole, non-empty chunks.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/add_if.sv
// Handshake bundle for add_pipe.
// Upstream side : in_valid/in_ready, a, b, cin.
// Downstream side: out_valid/out_ready, sum, cout, ovf.
// master = the environment around the adder, slave = the adder itself.
interface add_if import add_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice.
// Ports: a, b (CHUNK) operands, ci carry in; s (CHUNK) sum, co carry out,
// c_msb carry into the slice MSB (used for signed overflow in the top slice).
module add_chunk import add_pkg::*; #(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] full_s;

  // One extra bit holds the carry out; carry into the MSB is recovered from
  // the MSB sum bit, since s_msb = a_msb ^ b_msb ^ c_msb.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    s      = full_s[CHUNK-1:0];
    co     = full_s[CHUNK];
    c_msb  = full_s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
  end

endmodule

// File: rtl/add_pipe.sv
// Pipelined ripple-carry adder with valid/ready handshake on both sides.
// Ports: clk, rst_n (async active-low), bus (add_if.slave):
//   in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout/ovf out.
// Chunk k of the operands is delayed k cycles so it meets the carry from
// stage k-1; chunk k of the sum is then delayed STAGES-1-k cycles so all
// chunks of a transaction land in the output registers together.
// The whole pipeline advances as one: adv = !out_valid || out_ready.
module add_pipe import add_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic  clk,
  input  logic  rst_n,
  add_if.slave  bus
);

  localparam int STAGES = chunks(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("add_pipe: WIDTH must be a whole multiple of CHUNK and CHUNK >= 1");
  end

  logic              adv;
  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] carry_s;
  logic [WIDTH-1:0]  sum_s;
  logic              ovf_r;

  assign adv          = !valid_s[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = valid_s[STAGES-1];
  assign bus.sum      = sum_s;
  assign bus.cout     = carry_s[STAGES-1];
  assign bus.ovf      = ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SKEW   = k;
    localparam int DESKEW = STAGES - 1 - k;

    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic             ci;
    logic             v_in;
    logic [CHUNK-1:0] s_c;
    logic             co_c;
    logic             cm_c;
    logic [CHUNK-1:0] s_r;
    logic             co_r;
    logic             v_r;

    if (SKEW == 0) begin : g_noskew
      // First stage takes its chunk, carry and valid straight from the input.
      always_comb begin
        op_a = bus.a[CHUNK-1:0];
        op_b = bus.b[CHUNK-1:0];
        ci   = bus.cin;
        v_in = bus.in_valid;
      end
    end else begin : g_skew
      logic [CHUNK-1:0] a_dly_r [SKEW];
      logic [CHUNK-1:0] b_dly_r [SKEW];

      // Operand skew chain: delays this stage's chunk by SKEW cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < SKEW; j++) begin
            a_dly_r[j] <= {CHUNK{1'b0}};
            b_dly_r[j] <= {CHUNK{1'b0}};
          end
        end else if (adv) begin
          a_dly_r[0] <= bus.a[k*CHUNK +: CHUNK];
          b_dly_r[0] <= bus.b[k*CHUNK +: CHUNK];
          for (int j = 1; j < SKEW; j++) begin
            a_dly_r[j] <= a_dly_r[j-1];
            b_dly_r[j] <= b_dly_r[j-1];
          end
        end
      end

      // Later stages take the skewed chunk and the previous stage's state.
      always_comb begin
        op_a = a_dly_r[SKEW-1];
        op_b = b_dly_r[SKEW-1];
        ci   = carry_s[k-1];
        v_in = valid_s[k-1];
      end
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (op_a),
      .b     (op_b),
      .ci    (ci),
      .s     (s_c),
      .co    (co_c),
      .c_msb (cm_c)
    );

    // Stage register: chunk sum, outgoing carry and valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_r  <= {CHUNK{1'b0}};
        co_r <= 1'b0;
        v_r  <= 1'b0;
      end else if (adv) begin
        s_r  <= s_c;
        co_r <= co_c;
        v_r  <= v_in;
      end
    end

    assign valid_s[k] = v_r;
    assign carry_s[k] = co_r;

    if (DESKEW == 0) begin : g_nodeskew
      assign sum_s[k*CHUNK +: CHUNK] = s_r;
    end else begin : g_deskew
      logic [CHUNK-1:0] d_r [DESKEW];

      // Result deskew chain: holds this chunk until the top chunk catches up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DESKEW; j++) begin
            d_r[j] <= {CHUNK{1'b0}};
          end
        end else if (adv) begin
          d_r[0] <= s_r;
          for (int j = 1; j < DESKEW; j++) begin
            d_r[j] <= d_r[j-1];
          end
        end
      end

      assign sum_s[k*CHUNK +: CHUNK] = d_r[DESKEW-1];
    end

    if (k == STAGES - 1) begin : g_last
      // Signed overflow: carry into bit WIDTH-1 differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv) begin
          ovf_r <= co_c ^ cm_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sweep_rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   sweep_done [3];

  add_if #(.WIDTH(16)) bif ();
  add_pipe #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

  add_if #(.WIDTH(8)) b8 ();
  add_pipe #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] f;
    f = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    return {(a[15] == b[15]) && (f[15] != a[15]), f[16], f[15:0]};
  endfunction

  task automatic run_vec(input int i);
    int cyc;
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.a        = vecs[i].a;
    bif.b        = vecs[i].b;
    bif.cin      = vecs[i].cin;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    cyc = 1;
    while (!bif.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("vec%0d_latency", i), cyc, 32'd4);
    chk($sformatf("vec%0d_sum", i), {16'd0, bif.sum}, {16'd0, vecs[i].sum});
    chk($sformatf("vec%0d_cout", i), {31'd0, bif.cout}, {31'd0, vecs[i].cout});
    chk($sformatf("vec%0d_ovf", i), {31'd0, bif.ovf}, {31'd0, vecs[i].ovf});
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_pulse", i), {31'd0, bif.out_valid}, 32'd0);
  endtask

  // Random sweeps against a+b+cin with random backpressure.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 2) ? 12 : 16;
    localparam int C = (g == 0) ? 4 : ((g == 1) ? 1 : 3);

    add_if #(.WIDTH(W)) sif ();
    add_pipe #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .rst_n(sweep_rst_n), .bus(sif.slave));

    initial begin
      logic [W+1:0] q [$];
      logic [W+1:0] e;
      logic [W:0]   full;
      int           sent;
      int           got;
      string        nm;
      nm   = $sformatf("sweep_w%0d_c%0d", W, C);
      sent = 0;
      got  = 0;
      sif.in_valid  = 1'b0;
      sif.a         = '0;
      sif.b         = '0;
      sif.cin       = 1'b0;
      sif.out_ready = 1'b0;
      for (int i = 0; i < 20 && sweep_rst_n !== 1'b1; i++) @(negedge clk);
      for (int cyc = 0; cyc < 40000 && got < 10000; cyc++) begin
        @(negedge clk);
        sif.in_valid  = (sent < 10000) && ($urandom_range(0, 9) != 0);
        sif.a         = W'($urandom);
        sif.b         = W'($urandom);
        sif.cin       = 1'($urandom);
        sif.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (sif.out_valid && sif.out_ready) begin
          if (q.size() == 0) begin
            chk({nm, "_spurious"}, 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk(nm, 32'({sif.ovf, sif.cout, sif.sum}), 32'(e));
          end
          got++;
        end
        if (sif.in_valid && sif.in_ready) begin
          full = {1'b0, sif.a} + {1'b0, sif.b} + {{W{1'b0}}, sif.cin};
          q.push_back({(sif.a[W-1] == sif.b[W-1]) && (full[W-1] != sif.a[W-1]),
                       full[W], full[W-1:0]});
          sent++;
        end
      end
      chk({nm, "_count"}, got, 32'd10000);
      sweep_done[g] = 1'b1;
    end
  end

  initial begin
    logic [17:0] q [$];
    logic [17:0] held;
    logic [17:0] e;
    logic        exp_v;
    int          sent;
    int          got;
    int          stall_left;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    bif.in_valid = 1'b0; bif.a = 16'd0; bif.b = 16'd0; bif.cin = 1'b0; bif.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.a  = 8'd0;  b8.b  = 8'd0;  b8.cin  = 1'b0; b8.out_ready  = 1'b1;
    rst_n = 1'b1;
    sweep_rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    sweep_rst_n = 1'b0;
    #11;
    chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, bif.sum}, 32'd0);
    chk("rst_cout", {31'd0, bif.cout}, 32'd0);
    chk("rst_ovf", {31'd0, bif.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 7; i++) run_vec(i);

    // Back-to-back with a 3-cycle stall once results start
    sent = 0; got = 0; stall_left = -1; held = 18'd0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (bif.out_valid && stall_left < 0) stall_left = 3;
      bif.out_ready = !(stall_left > 0);
      bif.in_valid  = (sent < 6);
      bif.a   = 16'(sent + sent * 256);
      bif.b   = 16'hF0F0 + 16'(sent);
      bif.cin = sent[0];
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", {31'd0, bif.in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, bif.out_valid}, 32'd1);
        if (stall_left < 3) chk("stall_hold", 32'({bif.ovf, bif.cout, bif.sum}), 32'(held));
        held = {bif.ovf, bif.cout, bif.sum};
        stall_left--;
      end
      if (bif.out_valid && bif.out_ready) begin
        if (q.size() == 0) begin
          chk("stall_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stall_res%0d", got), 32'({bif.ovf, bif.cout, bif.sum}), 32'(e));
        end
        got++;
      end
      if (bif.in_valid && bif.in_ready) begin
        q.push_back(ref16(bif.a, bif.b, bif.cin));
        sent++;
      end
    end
    chk("stall_stalled", stall_left, 32'd0);
    chk("stall_got", got, 32'd6);
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_no_dup", {31'd0, bif.out_valid}, 32'd0);
    end

    // Bubbles: in_valid 1/0 for 8 cycles, out_valid follows 4 cycles later
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      exp_v = (j >= 4 && j < 12) ? ((j - 4) % 2 == 0) : 1'b0;
      chk($sformatf("bubble_valid%0d", j), {31'd0, bif.out_valid}, {31'd0, exp_v});
      if (exp_v) begin
        e = ref16(16'((j - 4) * 4369), 16'h0101, 1'b0);
        chk($sformatf("bubble_sum%0d", j), {16'd0, bif.sum}, {16'd0, e[15:0]});
      end
      bif.in_valid = (j < 8) && (j % 2 == 0);
      bif.a   = 16'(j * 4369);
      bif.b   = 16'h0101;
      bif.cin = 1'b0;
    end
    bif.in_valid = 1'b0;

    // Reset with 3 transactions in flight
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      bif.in_valid = 1'b1;
      bif.a = 16'h1111 * 16'(t + 1);
      bif.b = 16'h2222;
      bif.cin = 1'b1;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bif.in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, bif.sum}, 32'd0);
    chk("midrst_cout", {31'd0, bif.cout}, 32'd0);
    chk("midrst_ovf", {31'd0, bif.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, bif.out_valid}, 32'd0);
    end

    // Degenerate single-stage adder
    @(negedge clk);
    b8.in_valid = 1'b1; b8.a = 8'd200; b8.b = 8'd100; b8.cin = 1'b0;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    chk("deg_valid", {31'd0, b8.out_valid}, 32'd1);
    chk("deg_sum", {24'd0, b8.sum}, 32'd44);
    chk("deg_cout", {31'd0, b8.cout}, 32'd1);
    chk("deg_ovf", {31'd0, b8.ovf}, 32'd0);
    @(posedge clk);
    #1;
    chk("deg_pulse", {31'd0, b8.out_valid}, 32'd0);

    for (int i = 0; i < 50000 && !(sweep_done[0] && sweep_done[1] && sweep_done[2]); i++)
      @(posedge clk);
    chk("sweeps_finished", {29'd0, sweep_done[2], sweep_done[1], sweep_done[0]}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
Parametrised pipelined ripple-carry adder. It is the successor to the 4-bit combinational add_4.
Operands are split into CHUNK-bit slices, and one slice is added per pipeline stage, with the carry registered between stages. This gives a short critical path at one result per cycle.
A valid/ready handshake on both sides lets it sit between datapath blocks that apply backpressure.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per pipeline stage; 1 <= CHUNK <= WIDTH
(derived) STAGES = WIDTH/CHUNK, pipeline depth and latency in cycles

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      a/b/cin valid this cycle
in_ready   output  1      block accepts a/b/cin this cycle
a          input   WIDTH  operand A, unsigned/two's-complement
b          input   WIDTH  operand B
cin        input   1      carry in
out_valid  output  1      cout/sum/ovf valid
out_ready  input   1      downstream accepts result
sum        output  WIDTH  (a+b+cin) mod 2^WIDTH
cout       output  1      carry out of bit WIDTH-1
ovf        output  1      signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, carries, partial sums and operand skew registers clear to 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 from reset release.
- Advance enable: adv = !out_valid || out_ready.
  - adv is a global stall: all stages shift together, or none do.
  - in_ready = adv; this is combinational and is the only ready path.
- Transfer rule: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Stage k (0..STAGES-1) on adv:
  - Adds chunk k of a and b plus carry_k, where carry_0 = cin.
  - Registers the chunk sum, carry_{k+1} and the valid bit.
  - Stage STAGES-1 also registers ovf, from the carry into bit WIDTH-1.
- Operand skew: chunk k of a/b is delayed k cycles before entering stage k. Result deskew: chunk k of the sum is delayed STAGES-1-k cycles. All chunks of one transaction therefore appear in the output registers in the same cycle.
- Latency: a transaction accepted at edge N has out_valid=1 after edge N+STAGES-1, given no stall. sum/cout/ovf are registered outputs.
- Throughput: 1 transaction/cycle while out_ready=1.
- Bubbles: in_valid=0 while adv=1 inserts a bubble (valid=0 flows down). Data registers of bubble stages may hold garbage, but out_valid must be 0 for them.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0.
  - Every register holds.
  - sum/cout/ovf stay stable until accepted.
  - Nothing is dropped or duplicated.
- Simultaneous accept and consume in the same cycle: legal, and the pipeline shifts by one.
- Reset mid-operation: all in-flight transactions are discarded, and no partial result is ever presented.
- Degenerate case STAGES=1 (CHUNK=WIDTH): a single registered adder with latency 1 and the same handshake.
- Width rule: internal chunk add is CHUNK+1 bits wide; the MSB becomes the next carry.

Decomposition:
- Shared package add_pkg:
  - function chunks(WIDTH,CHUNK)
  - elaboration checks: WIDTH % CHUNK == 0, CHUNK >= 1
  - constants for default widths
- Natural sub-module: add_chunk. It is a combinational CHUNK-bit adder (a, b, ci -> s, co, plus carry-into-MSB for ovf) and is instantiated once per stage via generate.
- All registers, skew/deskew chains and handshake logic live in add_pipe.

Test Plan:
- Carry through all chunks (WIDTH=16, CHUNK=4, out_ready=1): a=16'hFFFF, b=16'h0001, cin=0 -> exactly 4 cycles later sum=16'h0000, cout=1, ovf=0, out_valid high for 1 cycle.
- Signed overflow and carry in: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1. Then a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0, ovf=0.
- Back-to-back with stall:
  - Stimulus: 6 consecutive transactions (i+i*256 pattern). Hold out_ready=0 for 3 cycles once the first result appears.
  - Required: in_ready=0 during the stall, output stable, all 6 results delivered in order against a reference model, no loss or duplication.
- Bubbles: alternate in_valid 1/0 for 8 cycles -> out_valid toggles with the same pattern delayed by 4 cycles, and only valid results are checked.
- Reset mid-flight: 3 transactions in flight, assert rst_n=0 asynchronously between edges -> out_valid=0 and sum=0 immediately. After release, no stale result ever appears, and in_ready=1.
- Degenerate parameters (WIDTH=8, CHUNK=8): a=200, b=100, cin=0 -> one cycle later sum=44, cout=1. Also run a random 10k-transaction sweep against a+b+cin for (16,4), (16,1) and (12,3).
